// File: rtl/ffnn_weight_loader_pkg.sv
// ============================================================================
// Module   : ffnn_pkg
// Brief    : Shared constants, helpers and loader state encoding for the
//            FFNN weight loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ffnn_pkg;

  function automatic int bytes_per_word(input int bits);
    return bits / 8;
  endfunction

  function automatic int total_words(input int in_sz, input int hid_sz,
                                     input int out_sz, input int bias_sz);
    return (in_sz + bias_sz) * hid_sz + (hid_sz + bias_sz) * out_sz;
  endfunction

  // Default-configuration geometry (32-bit words, 2-2-1 network, one bias row)
  localparam int BYTES_PER_WORD     = bytes_per_word(32);
  localparam int L0_ROWS            = 2 + 1;
  localparam int L0_COLS            = 2;
  localparam int L1_ROWS            = 2 + 1;
  localparam int L1_COLS            = 1;
  localparam int TOTAL_WEIGHT_WORDS = total_words(2, 2, 1, 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/ffnn_weight_loader_if.sv
// ============================================================================
// Module   : ffnn_weight_loader_if
// Brief    : Byte-stream handshake and core weight-write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ffnn_weight_loader_if #(
  parameter int BITS_PER_WORD = 32,
  parameter int N_W           = 2,
  parameter int M_W           = 2
) ();
  logic                     s_valid;
  logic                     s_ready;
  logic [7:0]               s_data;
  logic                     weights_en;
  logic                     weights_layer_address;
  logic [N_W-1:0]           weights_n_address;
  logic [M_W-1:0]           weights_m_address;
  logic [BITS_PER_WORD-1:0] weights_data;

  // Loader side: consumes bytes, drives the weight-write port
  modport slave (
    input  s_valid, s_data,
    output s_ready, weights_en, weights_layer_address,
           weights_n_address, weights_m_address, weights_data
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, weights_en, weights_layer_address,
           weights_n_address, weights_m_address, weights_data
  );
endinterface

`default_nettype wire

// File: rtl/ffnn_weight_addr_gen.sv
// ============================================================================
// Module   : ffnn_weight_addr_gen
// Brief    : layer/n/m weight address walker (m fastest) with last-word flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ffnn_weight_addr_gen #(
  parameter int N_W     = 2,
  parameter int M_W     = 2,
  parameter int L0_ROWS = 3,
  parameter int L0_COLS = 2,
  parameter int L1_ROWS = 3,
  parameter int L1_COLS = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear,
  input  logic           advance,
  output logic           layer,
  output logic [N_W-1:0] n_addr,
  output logic [M_W-1:0] m_addr,
  output logic           last
);

  logic           layer_q, layer_d;
  logic [N_W-1:0] n_q, n_d;
  logic [M_W-1:0] m_q, m_d;
  logic           n_last, m_last;

  always_comb begin
    n_last  = layer_q ? (n_q == N_W'(L1_ROWS - 1)) : (n_q == N_W'(L0_ROWS - 1));
    m_last  = layer_q ? (m_q == M_W'(L1_COLS - 1)) : (m_q == M_W'(L0_COLS - 1));
    last    = layer_q && n_last && m_last;
    layer_d = layer_q;
    n_d     = n_q;
    m_d     = m_q;
    if (clear) begin
      layer_d = 1'b0;
      n_d     = '0;
      m_d     = '0;
    end else if (advance) begin
      if (m_last) begin
        m_d = '0;
        if (n_last) begin
          n_d     = '0;
          // Leaving layer 1 wraps back to layer 0, so addresses idle at zero
          layer_d = ~layer_q;
        end else begin
          n_d = n_q + N_W'(1);
        end
      end else begin
        m_d = m_q + M_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      layer_q <= 1'b0;
      n_q     <= '0;
      m_q     <= '0;
    end else begin
      layer_q <= layer_d;
      n_q     <= n_d;
      m_q     <= m_d;
    end
  end

  assign layer  = layer_q;
  assign n_addr = n_q;
  assign m_addr = m_q;

endmodule

`default_nettype wire

// File: rtl/ffnn_weight_loader.sv
// ============================================================================
// Module   : ffnn_weight_loader
// Brief    : Assembles LE words from a byte stream and writes them to the
//            FFNN core. Optional trailer check: FFNN_WEIGHT_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ffnn_weight_loader
  import ffnn_pkg::*;
#(
  parameter int BITS_PER_WORD       = 32,
  parameter int INPUT_VECTOR_SIZE   = 2,
  parameter int HIDDEN_LAYER_SIZE   = 2,
  parameter int OUTPUT_VECTOR_SIZE  = 1,
  parameter int BIAS_SIZE           = 1,
  parameter int CLOG2_MAX_WEIGHTS_N = 2,
  parameter int CLOG2_MAX_WEIGHTS_M = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  ffnn_weight_loader_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  checksum_error
);

  localparam int c_bytes  = bytes_per_word(BITS_PER_WORD);
  localparam int c_bidx_w = (c_bytes > 1) ? $clog2(c_bytes) : 1;

  loader_state_e            state_q, state_d;
  logic [c_bidx_w-1:0]      bidx_q, bidx_d;
  logic [BITS_PER_WORD-1:0] word_q, word_d;
  logic [BITS_PER_WORD-1:0] data_q, data_d;
  logic                     s_ready_w, weights_en_w;
  logic                     accept, final_byte, addr_clear, addr_last;

  assign accept     = bus.s_valid && s_ready_w;
  assign final_byte = accept && (state_q == ST_RECV) &&
                      (bidx_q == c_bidx_w'(c_bytes - 1));
  assign addr_clear = (state_q == ST_IDLE) && start;

  ffnn_weight_addr_gen #(
    .N_W     (CLOG2_MAX_WEIGHTS_N),
    .M_W     (CLOG2_MAX_WEIGHTS_M),
    .L0_ROWS (INPUT_VECTOR_SIZE + BIAS_SIZE),
    .L0_COLS (HIDDEN_LAYER_SIZE),
    .L1_ROWS (HIDDEN_LAYER_SIZE + BIAS_SIZE),
    .L1_COLS (OUTPUT_VECTOR_SIZE)
  ) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (addr_clear),
    .advance (weights_en_w),
    .layer   (bus.weights_layer_address),
    .n_addr  (bus.weights_n_address),
    .m_addr  (bus.weights_m_address),
    .last    (addr_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RECV;
      ST_RECV:  if (final_byte) state_d = ST_WRITE;
`ifdef FFNN_WEIGHT_LOADER_CHECKSUM_EN
      ST_WRITE: state_d = addr_last ? ST_CHECK : ST_RECV;
`else
      ST_WRITE: state_d = addr_last ? ST_DONE : ST_RECV;
`endif
      ST_CHECK: if (accept) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready_w    = (state_q == ST_RECV) || (state_q == ST_CHECK);
    weights_en_w = (state_q == ST_WRITE);
    busy         = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
    done         = (state_q == ST_DONE);
  end

  // Output word is captured only on the final byte so it holds between writes
  always_comb begin
    bidx_d = bidx_q;
    word_d = word_q;
    data_d = data_q;
    if (addr_clear) begin
      bidx_d = '0;
      word_d = '0;
    end else if (accept && (state_q == ST_RECV)) begin
      word_d[8*bidx_q +: 8] = bus.s_data;
      bidx_d = final_byte ? '0 : bidx_q + c_bidx_w'(1);
      if (final_byte) data_d = word_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bidx_q <= '0;
      word_q <= '0;
      data_q <= '0;
    end else begin
      bidx_q <= bidx_d;
      word_q <= word_d;
      data_q <= data_d;
    end
  end

`ifdef FFNN_WEIGHT_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       cerr_q, cerr_d;

  always_comb begin
    csum_d = csum_q;
    cerr_d = cerr_q;
    if (addr_clear) begin
      csum_d = '0;
      cerr_d = 1'b0;
    end else if (accept && (state_q == ST_RECV)) begin
      csum_d = csum_q ^ bus.s_data;
    end else if (accept && (state_q == ST_CHECK) && (bus.s_data != csum_q)) begin
      cerr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
      cerr_q <= 1'b0;
    end else begin
      csum_q <= csum_d;
      cerr_q <= cerr_d;
    end
  end

  assign checksum_error = cerr_q;
`else
  assign checksum_error = 1'b0;
`endif

  assign bus.s_ready      = s_ready_w;
  assign bus.weights_en   = weights_en_w;
  assign bus.weights_data = data_q;

endmodule

`default_nettype wire

// File: tb/tb_ffnn_weight_loader.sv
// ============================================================================
// Module   : tb_ffnn_weight_loader
// Brief    : Scoreboard bench for ffnn_weight_loader (expected writes queued
//            by stimulus, popped by a negedge monitor).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ffnn_weight_loader;
  import ffnn_pkg::*;

  typedef struct packed {
    logic        l;
    logic [1:0]  n;
    logic [1:0]  m;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, checksum_error;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  wr_t exp_q[$];
  logic [31:0] words [9];

  // Hand-listed write order for the default 2-2-1 network
  logic       exp_l [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [1:0] exp_n [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2};
  logic [1:0] exp_m [9] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};

  always #5 clk = ~clk;

  ffnn_weight_loader_if #(.BITS_PER_WORD(32), .N_W(2), .M_W(2)) bus ();

  ffnn_weight_loader #(
    .BITS_PER_WORD       (32),
    .INPUT_VECTOR_SIZE   (2),
    .HIDDEN_LAYER_SIZE   (2),
    .OUTPUT_VECTOR_SIZE  (1),
    .BIAS_SIZE           (1),
    .CLOG2_MAX_WEIGHTS_N (2),
    .CLOG2_MAX_WEIGHTS_M (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .checksum_error (checksum_error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t got;
    wr_t e;
    if (bus.weights_en === 1'b1) begin
      got = {bus.weights_layer_address, bus.weights_n_address,
             bus.weights_m_address, bus.weights_data};
      wr_cnt++;
      check("s_ready_in_write", 64'(bus.s_ready), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(got), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("write", 64'(got), 64'(e));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("busy_at_done", 64'(busy), 64'd0);
      check("writes_before_done", 64'(exp_q.size()), 64'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int t;
    t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    forever begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      t++;
      if (t > 200) begin
        check("byte_timeout", 64'd1, 64'd0);
        break;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
    check({tag, "_weights_en"}, 64'(bus.weights_en), 64'd0);
    check({tag, "_addr"}, 64'({bus.weights_layer_address, bus.weights_n_address,
                                bus.weights_m_address}), 64'd0);
    check({tag, "_data"}, 64'(bus.weights_data), 64'd0);
    check({tag, "_busy_done_cerr"}, 64'({busy, done, checksum_error}), 64'd0);
  endtask

  task automatic load(input int gap_word, input int start_word, input bit bad_trailer);
    logic [7:0] x;
    int d0;
    int w0;
    x  = 8'h00;
    d0 = done_cnt;
    w0 = wr_cnt;
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    check("cerr_cleared_by_start", 64'(checksum_error), 64'd0);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({exp_l[i], exp_n[i], exp_m[i], words[i]});
      for (int b = 0; b < 4; b++) begin
        send_byte(words[i][8*b +: 8]);
        x = x ^ words[i][8*b +: 8];
        if (i == gap_word && b == 1) begin : gap
          int wg;
          wg = wr_cnt;
          pulse_start();
          repeat (4) @(posedge clk);
          #1;
          check("no_early_write", 64'(wr_cnt), 64'(wg));
        end
        if (i == start_word && b == 3) pulse_start();
      end
    end
`ifdef FFNN_WEIGHT_LOADER_CHECKSUM_EN
    send_byte(bad_trailer ? (x ^ 8'h01) : x);
`endif
    for (int t = 0; t < 50 && done_cnt == d0; t++) @(posedge clk);
    #1;
    check("done_seen", 64'(done_cnt - d0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("single_done", 64'(done_cnt - d0), 64'd1);
    check("write_count", 64'(wr_cnt - w0), 64'(TOTAL_WEIGHT_WORDS));
    check("busy_after_done", 64'(busy), 64'd0);
    check("cerr_after_done", 64'(checksum_error), 64'(bad_trailer));
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Bytes offered in IDLE must not be taken
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      check("idle_s_ready", 64'(bus.s_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;

    // Nominal load: includes 00 00 01 00 -> 1.0 and 00 00 FF FF -> -1.0
    words = '{32'h0001_0000, 32'hFFFF_0000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_8000,
              32'h8000_0001, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'h00FF_00FF};
    load(-1, -1, 1'b0);

    // Mid-word stall with start pulsed in RECV, start pulsed during a WRITE
    words = '{32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4, 32'hD1D2_D3D4, 32'hE1E2_E3E4,
              32'hF1F2_F3F4, 32'h0102_0304, 32'h1112_1314, 32'h2122_2324};
    load(2, 4, 1'b0);

    // Reset after the 4th write with two stale bytes of word 5 pending
    begin : mid_reset
      int w0;
      w0 = wr_cnt;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back({exp_l[i], exp_n[i], exp_m[i], words[i]});
        for (int b = 0; b < 4; b++) send_byte(words[i][8*b +: 8]);
      end
      send_byte(8'hAA);
      send_byte(8'hBB);
      check("writes_before_reset", 64'(wr_cnt - w0), 64'd4);
      reset_n = 1'b0;
      #2;
      check_idle_outputs("midreset");
      repeat (2) @(posedge clk);
      #1;
      check("writes_during_reset", 64'(wr_cnt - w0), 64'd4);
      check("queue_after_partial", 64'(exp_q.size()), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
    end

    words = '{32'h1357_9BDF, 32'h2468_ACE0, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000,
              32'h0102_0408, 32'h1020_4080, 32'hCAFE_F00D, 32'h5555_AAAA};
    load(-1, -1, 1'b0);

`ifdef FFNN_WEIGHT_LOADER_CHECKSUM_EN
    load(-1, -1, 1'b1);
    load(-1, -1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
